// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data stages.
// Define ARB_RR_EN for round-robin arbitration; default is data-first.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_en,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic          r_owner;
    logic          r_wr;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          r_if_done;
    logic          r_d_done;
    logic          w_any_req;
    logic          w_grant_d;

    assign w_any_req = if_req | d_req;

`ifdef ARB_RR_EN
    logic r_last;

    // Grant data unless fetch also asks and data was granted last.
    always_comb begin
        w_grant_d = d_req & (~if_req | ~r_last);
    end

    // Remember who won the most recent grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= 1'b0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last <= w_grant_d;
        end
    end
`else
    // Data requests always beat fetch.
    always_comb begin
        w_grant_d = d_req;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_any_req) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (MEM_LAT == 1) w_next = S_CAPTURE;
                else              w_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) w_next = S_CAPTURE;
            end
            S_CAPTURE: w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Request latch, latency counter, read capture and done pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= 4'd0;
            r_owner    <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_done  <= 1'b0;
            r_d_done   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_owner <= w_grant_d;
                r_wr    <= w_grant_d & d_wr;
                r_addr  <= w_grant_d ? d_addr : if_addr;
                r_wdata <= d_wdata;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= LAT_M1;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == S_CAPTURE && !r_wr) begin
                if (r_owner) r_d_rdata  <= mem_rdata;
                else         r_if_rdata <= mem_rdata;
            end
            r_if_done <= (r_state == S_CAPTURE) & ~r_owner;
            r_d_done  <= (r_state == S_CAPTURE) & r_owner;
        end
    end

    assign mem_en    = (r_state == S_ISSUE);
    assign mem_rd    = mem_en & ~r_wr;
    assign mem_wr    = mem_en & r_wr;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign if_done   = r_if_done;
    assign d_done    = r_d_done;
    assign busy      = (r_state != S_IDLE);
    assign owner     = r_owner;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single-port data/instruction memory between two requesters: the fetch stage (instruction reads) and the memory stage (loads/stores).
- Sits between the Fetch/Memory stage logic and the memory array.
- Serialises accesses through a small FSM, absorbs the memory's fixed read latency, and returns a registered one-cycle done pulse to each requester.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 1, memory read latency in cycles from the issue cycle to valid mem_rdata (legal range 1..15; 0 illegal)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
if_req  input  1  fetch read request; held high until if_done
if_addr  input  AW  fetch address
if_rdata  output  DW  fetched instruction, registered
if_done  output  1  one-cycle completion pulse to fetch
d_req  input  1  data request; held high until d_done
d_wr  input  1  1=store, 0=load; held with d_req
d_addr  input  AW  data address
d_wdata  input  DW  store data
d_rdata  output  DW  load data, registered
d_done  output  1  one-cycle completion pulse to data stage
mem_en  output  1  memory access strobe
mem_rd  output  1  memory read
mem_wr  output  1  memory write
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data
busy  output  1  high when the FSM is not in IDLE
owner  output  1  0=fetch, 1=data; valid while busy

Behaviour:
- Reset values (reset low, asynchronous): state=IDLE; all outputs 0 (mem_en, mem_rd, mem_wr, mem_addr, mem_wdata, if_rdata, d_rdata, if_done, d_done, busy, owner); latency counter=0.
- Reset mid-operation abandons the in-flight access immediately; no done pulse is issued for it.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- IDLE:
  - If either req is high, pick the winner, latch addr/wr/wdata/owner, go to ISSUE.
  - Fixed priority: d_req wins over if_req.
  - If no req is high, stay in IDLE.
- ISSUE (1 cycle):
  - mem_en=1.
  - mem_rd=1 for a fetch or load; mem_wr=1 for a store.
  - mem_addr and mem_wdata are driven from the latched values.
  - Load counter with MEM_LAT-1; go to WAIT, or straight to CAPTURE if MEM_LAT=1.
- WAIT: decrement the counter each cycle; go to CAPTURE when the counter reaches 0.
  - mem_en, mem_rd and mem_wr are 0 in WAIT, CAPTURE and DONE.
- CAPTURE:
  - mem_rdata is valid in this cycle (issue cycle + MEM_LAT).
  - On a read, register it into if_rdata or d_rdata according to owner.
  - On a store, nothing is captured and d_rdata holds its previous value.
  - Go to DONE.
- DONE: the owner's done pulses high for exactly 1 cycle; go to IDLE.
- Latency: req first seen in IDLE at cycle 0 → ISSUE at cycle 1 → done at cycle MEM_LAT+2. Stores have the same timing.
- Handshake rules:
  - The requester keeps req, addr, wr and wdata stable until it sees done.
  - req must be low in the cycle after done, otherwise the request is re-served as a new access.
  - A req raised in any non-IDLE state is only evaluated when the FSM returns to IDLE.
  - There is always one IDLE cycle between consecutive accesses.
- if_rdata and d_rdata hold their values until the next capture for the same owner.
- Simultaneous if_req and d_req: one access at a time; the loser waits with its req held and is served after the winner's DONE plus one IDLE cycle.
- The arbiter never modifies addresses or data; no address checking is performed.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin priority.
  - A 1-bit last_owner register (reset 0) tracks the most recent grant.
  - On contention in IDLE, the requester that was not last granted wins; last_owner updates on every grant.
- Undefined: fixed priority, data always wins; no last_owner register exists.

Test Plan:
- Fetch, MEM_LAT=1, if_req at cycle 0, if_addr=0x10, memory returns 0xDEADBEEF:
  - cycle 1: mem_en=1, mem_rd=1, mem_addr=0x10.
  - cycle 3: if_done=1, if_rdata=0xDEADBEEF.
  - busy=1 for cycles 1-3.
- Contention, d_req (load 0x20 → 0xCAFEF00D) and if_req (0x10) both at cycle 0, ARB_RR_EN undefined:
  - data issued cycle 1, d_done cycle 3.
  - cycle 4 IDLE; fetch issued cycle 5, if_done cycle 7.
- Store, d_wr=1, d_addr=0x40, d_wdata=0x12345678:
  - mem_wr=1 only in cycle 1, with mem_addr=0x40 and mem_wdata=0x12345678.
  - d_done cycle 3; d_rdata unchanged from its prior value.
- MEM_LAT=3, fetch at cycle 0: ISSUE cycle 1, CAPTURE cycle 4, if_done cycle 5 with the data present at cycle 4.
- Reset mid-operation: drive reset low during WAIT (MEM_LAT=3, cycle 2):
  - immediately mem_en=0, busy=0, all outputs 0.
  - no done pulse is produced.
  - after release with req still held, access re-issued 1 cycle later, done MEM_LAT+2 cycles after that.
- ARB_RR_EN defined, both reqs re-raised after every done for 4 grants:
  - grant order data, fetch, data, fetch.
  - with the macro undefined: data, data, data, data while d_req persists.
